// File: rtl/ebr_mode_pkg.sv
// ebr_mode_pkg: EBR narrow-width mode constants plus address split and lane helpers
// shared by the read unpacker and the write-mask decoder.
package ebr_mode_pkg;

    localparam int MODE_W16 = 0;
    localparam int MODE_W8  = 1;
    localparam int MODE_W4  = 2;
    localparam int MODE_W2  = 3;

    typedef struct packed {
        logic [7:0] word;
        logic [2:0] lane;
    } addr_split_t;

    function automatic addr_split_t addr_split(input int mode, input logic [10:0] addr);
        addr_split_t s;
        s.word = (mode == MODE_W8) ? addr[8:1] :
                 (mode == MODE_W4) ? addr[9:2] :
                 (mode == MODE_W2) ? addr[10:3] : addr[7:0];
        s.lane = (mode == MODE_W8) ? {2'b00, addr[0]} :
                 (mode == MODE_W4) ? {1'b0, addr[1:0]} :
                 (mode == MODE_W2) ? addr[2:0] : 3'd0;
        return s;
    endfunction

    // Narrow lanes are interleaved: lane L of an N-lane word owns bits L, L+N, L+2N, ...
    function automatic logic [15:0] lane_extract(input int mode, input logic [2:0] lane,
                                                 input logic [15:0] word);
        logic [15:0] r;
        r = '0;
        if (mode == MODE_W8) begin
            for (int k = 0; k < 8; k++) r[k] = word[2*k + int'(lane[0])];
        end else if (mode == MODE_W4) begin
            for (int k = 0; k < 4; k++) r[k] = word[4*k + int'(lane[1:0])];
        end else if (mode == MODE_W2) begin
            r[1:0] = {word[8 + int'(lane)], word[int'(lane)]};
        end else begin
            r = word;
        end
        return r;
    endfunction

    function automatic logic [15:0] lane_mask(input int mode, input logic [2:0] lane);
        logic [15:0] m;
        m = '0;
        for (int b = 0; b < 16; b++) m[b] = ((b & ((1 << mode) - 1)) == int'(lane));
        return m;
    endfunction

endpackage

// File: rtl/rsp_fifo2.sv
// rsp_fifo2: 2-entry 16-bit response FIFO; head data and valid come straight from
// registers so they stay stable while the consumer stalls.
module rsp_fifo2 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_push,
    input  logic [15:0] i_data,
    input  logic        i_pop,
    output logic        o_valid,
    output logic [15:0] o_data,
    output logic [1:0]  o_occ
);

    logic [15:0] r_mem [2];
    logic        r_wr;
    logic        r_rd;
    logic [1:0]  r_occ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= ~r_wr;
            end
            if (i_pop) r_rd <= ~r_rd;
            r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_valid = (r_occ != 2'd0);
    assign o_data  = r_mem[r_rd];
    assign o_occ   = r_occ;

endmodule

// File: rtl/ebr_read_unpack.sv
// ebr_read_unpack: serves narrow-width reads from a 256x16 EBR by word read,
// lane extraction and a 2-entry backpressured response buffer.
module ebr_read_unpack
    import ebr_mode_pkg::*;
#(
    parameter int READ_MODE = MODE_W16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [10:0] req_addr,
    output logic        ram_re,
    output logic [7:0]  ram_raddr,
    input  logic [15:0] ram_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data
);

    if (READ_MODE < MODE_W16 || READ_MODE > MODE_W2) begin : g_bad_mode
        $fatal(1, "ebr_read_unpack: READ_MODE %0d outside 0..3", READ_MODE);
    end

    addr_split_t w_split;
    logic        w_accept;
    logic        w_pop;
    logic [1:0]  w_occ;
    logic [1:0]  w_level;
    logic [15:0] w_lane_data;
    logic        r_inflight;
    logic [2:0]  r_lane;

    assign w_split = addr_split(READ_MODE, req_addr);
    assign w_pop   = rsp_valid & rsp_ready;
    // Buffered plus in-flight responses never exceed 2, so a 2-bit level cannot wrap.
    assign w_level   = w_occ + {1'b0, r_inflight} - {1'b0, w_pop};
    assign req_ready = (w_level < 2'd2);
    assign w_accept  = req_valid & req_ready & rst_n;
    assign ram_re    = w_accept;
    assign ram_raddr = w_accept ? w_split.word : 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_lane     <= 3'd0;
        end else begin
            r_inflight <= w_accept;
            if (w_accept) r_lane <= w_split.lane;
        end
    end

    assign w_lane_data = lane_extract(READ_MODE, r_lane, ram_rdata);

    rsp_fifo2 u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_inflight),
        .i_data  (w_lane_data),
        .i_pop   (w_pop),
        .o_valid (rsp_valid),
        .o_data  (rsp_data),
        .o_occ   (w_occ)
    );

endmodule

// File: tb/tb_ebr_read_unpack.sv
// tb_ebr_read_unpack: one instance per read mode, each backed by a behavioural RAM,
// checked against a narrow-view reference model and an in-order scoreboard.
module tb_ebr_read_unpack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid, req_ready, ram_re, rsp_valid, rsp_ready;
    logic [10:0] req_addr [4];
    logic [7:0]  ram_raddr [4];
    logic [15:0] ram_rdata [4];
    logic [15:0] rsp_data [4];
    logic [15:0] mem [4][256];

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc_n = 0;
    logic [15:0] expq [4][$];
    int          accq [4][$];
    logic [15:0] dir_q [$];
    bit          lat_chk;
    bit   [3:0]  held;
    logic [15:0] held_d [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        ebr_read_unpack #(.READ_MODE(g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_addr  (req_addr[g]),
            .ram_re    (ram_re[g]),
            .ram_raddr (ram_raddr[g]),
            .ram_rdata (ram_rdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_data  (rsp_data[g])
        );
        always @(posedge clk) if (ram_re[g]) ram_rdata[g] <= mem[g][ram_raddr[g]];
    end

    // Narrow view of the RAM: element a of mode m is 16>>m bits wide and lives in
    // word a/2^m, using every 2^m-th bit starting at bit a mod 2^m.
    function automatic logic [15:0] ref_read(input int m, input logic [10:0] a);
        int n = 1 << m;
        int w = 16 >> m;
        int wa = (int'(a) >> m) & 255;
        int ln = int'(a) % n;
        logic [15:0] r = '0;
        for (int k = 0; k < w; k++) r[k] = mem[m][wa][k*n + ln];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int m, output bit acc);
        logic [15:0] e;
        int a;
        acc = 1'b0;
        @(negedge clk);
        if (held[m]) begin
            chk("hold_valid", rsp_valid[m], 1);
            chk("hold_data", rsp_data[m], held_d[m]);
        end
        held[m] = rsp_valid[m] & ~rsp_ready[m];
        held_d[m] = rsp_data[m];
        if (rsp_valid[m] && rsp_ready[m]) begin
            if (expq[m].size() == 0) chk("spurious_rsp", rsp_valid[m], 0);
            else begin
                e = expq[m].pop_front();
                a = accq[m].pop_front();
                chk("rsp_data", rsp_data[m], e);
                if (lat_chk) chk("latency", cyc_n - a, 2);
            end
        end
        if (req_valid[m] && req_ready[m]) begin
            acc = 1'b1;
            chk("ram_re", ram_re[m], 1);
            chk("ram_raddr", ram_raddr[m], (int'(req_addr[m]) >> m) & 255);
            expq[m].push_back(dir_q.size() != 0 ? dir_q.pop_front() : ref_read(m, req_addr[m]));
            accq[m].push_back(cyc_n);
        end else begin
            chk("ram_re_idle", ram_re[m], 0);
        end
        @(posedge clk);
        cyc_n++;
        #1;
    endtask

    task automatic idle(input int m, input int n);
        bit d;
        repeat (n) tick(m, d);
    endtask

    initial begin
        bit acc;
        int idx;
        logic [10:0] bp_addr [4];
        req_valid = '0;
        rsp_ready = '1;
        lat_chk = 1'b0;
        held = '0;
        for (int m = 0; m < 4; m++) begin
            req_addr[m] = '0;
            for (int w = 0; w < 256; w++) mem[m][w] = 16'($urandom);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int m = 0; m < 4; m++) begin
            chk("rst_req_ready", req_ready[m], 1);
            chk("rst_ram_re", ram_re[m], 0);
            chk("rst_ram_raddr", ram_raddr[m], 0);
            chk("rst_rsp_valid", rsp_valid[m], 0);
            chk("rst_rsp_data", rsp_data[m], 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        lat_chk = 1'b1;
        mem[1][3] = 16'h5555;
        req_valid[1] = 1'b1;
        req_addr[1] = 11'd6;
        dir_q.push_back(16'h00FF);
        tick(1, acc);
        chk("m1_acc", acc, 1);
        req_addr[1] = 11'd7;
        dir_q.push_back(16'h0000);
        tick(1, acc);
        req_valid[1] = 1'b0;
        dir_q.delete();
        idle(1, 4);
        chk("m1_drain", expq[1].size(), 0);

        mem[2][1] = 16'h8421;
        req_valid[2] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr[2] = 11'(4 + i);
            dir_q.push_back(16'(1 << i));
            tick(2, acc);
            chk("m2_acc", acc, 1);
        end
        req_valid[2] = 1'b0;
        dir_q.delete();
        idle(2, 4);
        chk("m2_drain", expq[2].size(), 0);

        mem[3][0] = 16'h0100;
        req_valid[3] = 1'b1;
        req_addr[3] = 11'd0;
        dir_q.push_back(16'h0002);
        tick(3, acc);
        req_addr[3] = 11'd1;
        dir_q.push_back(16'h0000);
        tick(3, acc);
        req_valid[3] = 1'b0;
        dir_q.delete();
        idle(3, 4);
        chk("m3_drain", expq[3].size(), 0);

        mem[0][8'h2A] = 16'hBEEF;
        req_valid[0] = 1'b1;
        req_addr[0] = 11'h72A;
        dir_q.push_back(16'hBEEF);
        tick(0, acc);
        req_valid[0] = 1'b0;
        dir_q.delete();
        idle(0, 4);
        chk("m0_drain", expq[0].size(), 0);

        lat_chk = 1'b0;
        for (int i = 0; i < 4; i++) bp_addr[i] = 11'($urandom);
        rsp_ready[2] = 1'b0;
        req_valid[2] = 1'b1;
        idx = 0;
        repeat (4) begin
            req_addr[2] = bp_addr[idx];
            tick(2, acc);
            if (acc) idx++;
        end
        chk("bp_accepts", idx, 2);
        chk("bp_req_ready", req_ready[2], 0);
        rsp_ready[2] = 1'b1;
        for (int t = 0; t < 20 && idx < 4; t++) begin
            req_addr[2] = bp_addr[idx];
            tick(2, acc);
            if (acc) idx++;
        end
        req_valid[2] = 1'b0;
        chk("bp_all_accepted", idx, 4);
        idle(2, 4);
        chk("bp_drain", expq[2].size(), 0);

        for (int m = 0; m < 4; m++) begin
            repeat (80) begin
                req_valid[m] = ($urandom_range(3) != 0);
                req_addr[m] = 11'($urandom);
                rsp_ready[m] = ($urandom_range(2) != 0);
                tick(m, acc);
            end
            req_valid[m] = 1'b0;
            rsp_ready[m] = 1'b1;
            for (int t = 0; t < 8 && expq[m].size() != 0; t++) tick(m, acc);
            chk("rand_drain", expq[m].size(), 0);
        end

        req_valid[1] = 1'b1;
        req_addr[1] = 11'($urandom);
        tick(1, acc);
        chk("rstmid_acc", acc, 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_req_ready", req_ready[1], 1);
        chk("rstmid_ram_re", ram_re[1], 0);
        chk("rstmid_ram_raddr", ram_raddr[1], 0);
        chk("rstmid_rsp_valid", rsp_valid[1], 0);
        chk("rstmid_rsp_data", rsp_data[1], 0);
        req_valid[1] = 1'b0;
        for (int m = 0; m < 4; m++) begin
            expq[m].delete();
            accq[m].delete();
        end
        held = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) begin
            tick(1, acc);
            chk("rstmid_no_rsp", rsp_valid[1], 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ebr_read_unpack.md
# ebr_read_unpack

Read-side companion to the EBR write-mask path. It serves narrow-width reads (512x8, 1024x4, 2048x2) from a physical 256x16 embedded block RAM. Each narrow read request becomes a 16-bit word read. The block then selects the bit lane that the write mask enabled for the same address, right-justifies it, and returns it through a backpressured response port. It sits between a narrow-width client and the RAM read port, with a 2-entry response buffer to sustain one read per cycle.

## Interface
- `READ_MODE`, default 0: 0 = 256x16, 1 = 512x8, 2 = 1024x4, 3 = 2048x2; any other value is a fatal elaboration error.
- `clk`, in, 1: single clock; all state on rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `req_valid`, in, 1: read request valid.
- `req_ready`, out, 1: request accepted when `req_valid & req_ready`.
- `req_addr`, in, 11: narrow address; bits above the mode's width are ignored.
- `ram_re`, out, 1: RAM read enable.
- `ram_raddr`, out, 8: RAM word address.
- `ram_rdata`, in, 16: RAM read data, valid the cycle after `ram_re`.
- `rsp_valid`, out, 1: response valid.
- `rsp_ready`, in, 1: response consumed when `rsp_valid & rsp_ready`.
- `rsp_data`, out, 16: lane data, right-justified; unused upper bits are 0.

## Operation
- Address split by mode (word / lane):
  - mode 0: `addr[7:0]` / none.
  - mode 1: `addr[8:1]` / `addr[0]`.
  - mode 2: `addr[9:2]` / `addr[1:0]`.
  - mode 3: `addr[10:3]` / `addr[2:0]`.
- Lane extraction, the exact inverse of the write mask:
  - mode 0: `rsp_data = word`.
  - mode 1: `rsp_data[k] = word[2k+L]`, k = 0..7.
  - mode 2: `rsp_data[k] = word[4k+L]`, k = 0..3.
  - mode 3: `rsp_data[1:0] = {word[8+L], word[L]}`.
- Issue stage:
  - On accept: `ram_re = 1` and `ram_raddr` = word address, both combinational from the request.
  - The lane is registered into `inflight_lane`, and the `inflight` flag is set for one cycle.
- Capture stage: when `inflight = 1`, the extracted `ram_rdata` lane is pushed into the 2-entry response FIFO at the end of that cycle.
- Flow control:
  - `req_ready = (occ + inflight - pop) < 2`, where `pop = rsp_valid & rsp_ready`. `req_ready` therefore depends combinationally on `rsp_ready`.
  - The FIFO never overflows, and no in-flight read is ever dropped.
- Ordering: responses are returned strictly in request order.
- Reset values: `req_ready = 1`, `ram_re = 0`, `ram_raddr = 0`, `rsp_valid = 0`, `rsp_data = 0`, `occ = 0`, `inflight = 0`.
- Reset mid-operation: in-flight reads and buffered responses are discarded with no later response; `ram_re` is forced low while `rst_n = 0`.

## Timing
- Latency: a request accepted in cycle N gives `rsp_valid = 1` in cycle N+2 when the FIFO was empty.
- Throughput: one request per cycle sustained while `rsp_ready = 1`.
- Stall: with `rsp_ready = 0`, at most 2 requests complete. After that, `req_ready = 0` until a pop occurs.
- Simultaneous push and pop: `occ` is unchanged, and the head advances to the next entry.
- `rsp_data` and `rsp_valid` come from FIFO registers and are stable while `rsp_valid & !rsp_ready`.
- There is no FSM. State is `inflight`, `inflight_lane`, the FIFO pointers (1 bit each) and `occ` (0..2).

## Structure
- Package `ebr_mode_pkg`:
  - mode constants `MODE_W16`, `MODE_W8`, `MODE_W4`, `MODE_W2`.
  - function `lane_extract(mode, lane, word)`.
  - function `addr_split(mode, addr)`.
- The write-mask decoder should reuse the same constants.
- One sub-module: `rsp_fifo2`, a 2-entry, 16-bit FIFO with `push`, `pop`, `occ`, and registered head output.

## Test plan
- Mode 1, RAM word 3 = `0x5555`: read addr 6 → `rsp_data = 0x00FF`; read addr 7 → `0x0000`. `ram_raddr = 3` both times.
- Mode 2, RAM word 1 = `0x8421`: read addrs 4, 5, 6, 7 back-to-back → `0x1`, `0x2`, `0x4`, `0x8` on 4 consecutive cycles starting 2 cycles after the first accept.
- Mode 3, RAM word 0 = `0x0100`: read addr 0 → `0x2`; addr 1 → `0x0`. Mode 0 with word `0xBEEF` → `0xBEEF`.
- Backpressure: hold `rsp_ready = 0` and issue 4 requests. Exactly 2 are accepted, then `req_ready = 0`. Release `rsp_ready`: the remaining requests complete in order with no loss or duplication.
- Reset: assert `rst_n = 0` one cycle after an accept. All outputs go to their reset values immediately, and no response appears after reset is released.
